// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 FFT butterfly/twiddle address sequencer: walks L stages of N/2 butterflies under a valid/ready handshake.
// Optional feature: define FFT_SEQ_ABORT_EN to add an abort input that cancels a running transform.
module fft_twiddle_sequencer #(
  parameter int MAX_N      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            log2n,
  input  logic                  bf_ready,
  output logic                  bf_valid,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] tw_k,
  output logic [ADDR_WIDTH:0]   tw_n,
  output logic [3:0]            stage,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
`ifdef FFT_SEQ_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int AW   = ADDR_WIDTH;
  localparam int LMAX = ($clog2(MAX_N) < ADDR_WIDTH) ? $clog2(MAX_N) : ADDR_WIDTH;
  localparam logic [4:0]    LMAX_V = 5'(LMAX);
  localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   ONE_N  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      l_q, l_d, s_q, s_d;
  logic [AW-1:0]   j_q, j_d;
  logic            bf_valid_q, bf_valid_d, busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d, tw_k_q, tw_k_d;
  logic [AW:0]     tw_n_q, tw_n_d;
  logic [3:0]      stage_q, stage_d;
  logic [AW-1:0]   j_last_s, span_s, pos_s;
  logic            accept_s, log2n_ok_s;

  // Next-state, counter stepping and descriptor generation (shift/mask only).
  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    s_d        = s_q;
    j_d        = j_q;
    bf_valid_d = bf_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    accept_s   = bf_valid_q & bf_ready;
    log2n_ok_s = (log2n != 4'd0) && ({1'b0, log2n} <= LMAX_V);
    j_last_s   = (ONE_A << (l_q - 4'd1)) - ONE_A;

    case (state_q)
      IDLE: begin
        if (start && log2n_ok_s) begin
          l_d        = log2n;
          s_d        = 4'd0;
          j_d        = '0;
          state_d    = RUN;
          bf_valid_d = 1'b1;
          busy_d     = 1'b1;
        end else if (start) begin
          cfg_err_d  = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      RUN: begin
`ifdef FFT_SEQ_ABORT_EN
        if (abort) begin
          state_d    = IDLE;
          bf_valid_d = 1'b0;
          busy_d     = 1'b0;
        end else
`endif
        if (accept_s && (j_q == j_last_s) && (s_q == (l_q - 4'd1))) begin
          state_d    = DONE;
          bf_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (accept_s && (j_q == j_last_s)) begin
          s_d        = s_q + 4'd1;
          j_d        = '0;
        end else if (accept_s) begin
          j_d        = j_q + ONE_A;
        end else begin
          j_d        = j_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        bf_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

    // Counters hold when nothing advances, so the descriptor holds with them.
    span_s   = ONE_A << s_d;
    pos_s    = j_d & (span_s - ONE_A);
    addr_a_d = ((j_d >> s_d) << (s_d + 4'd1)) | pos_s;
    addr_b_d = addr_a_d | span_s;
    tw_k_d   = pos_s;
    tw_n_d   = ONE_N << (s_d + 4'd1);
    stage_d  = s_d;
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      l_q        <= 4'd0;
      s_q        <= 4'd0;
      j_q        <= '0;
      bf_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_k_q     <= '0;
      tw_n_q     <= ONE_N << 1;
      stage_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      s_q        <= s_d;
      j_q        <= j_d;
      bf_valid_q <= bf_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_k_q     <= tw_k_d;
      tw_n_q     <= tw_n_d;
      stage_q    <= stage_d;
    end
  end

  assign bf_valid = bf_valid_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_k     = tw_k_q;
  assign tw_n     = tw_n_q;
  assign stage    = stage_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: doc/fft_twiddle_sequencer.md
FFT_TWIDDLE_SEQUENCER -- requirements
Module: fft_twiddle_sequencer

Interface
REQ-001 SHALL have parameter MAX_N, default 1024: largest supported FFT size.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: log2(MAX_N).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new transform.
REQ-006 SHALL have port log2n, input, 4 bits: transform size exponent, valid range 1..ADDR_WIDTH, sampled only when start is accepted.
REQ-007 SHALL have port bf_ready, input, 1 bit: butterfly datapath accepts the current descriptor.
REQ-008 SHALL have port bf_valid, output, 1 bit: current descriptor valid.
REQ-009 SHALL have port addr_a, output, ADDR_WIDTH bits: upper butterfly operand index.
REQ-010 SHALL have port addr_b, output, ADDR_WIDTH bits: lower butterfly operand index.
REQ-011 SHALL have port tw_k, output, ADDR_WIDTH bits: twiddle index k for the twiddle ROM.
REQ-012 SHALL have port tw_n, output, ADDR_WIDTH+1 bits: current group size for the twiddle ROM n input.
REQ-013 SHALL have port stage, output, 4 bits: current stage number, 0-based.
REQ-014 SHALL have port busy, output, 1 bit: high in RUN.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port cfg_err, output, 1 bit: one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE, with all outputs registered.
REQ-018 IDLE with start=1 and log2n in 1..ADDR_WIDTH SHALL latch L=log2n, clear the stage and butterfly counters, and enter RUN next cycle with bf_valid=1 (1-cycle latency).
REQ-019 IDLE with start=1 and log2n outside 1..ADDR_WIDTH SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE.
REQ-021 For stage s and butterfly index j (0..N/2-1, N=2^L), with span=2^s, pos=j mod span and g=j>>s:
- addr_a = g*2^(s+1)+pos
- addr_b = addr_a+span
- tw_k = pos
- tw_n = 2^(s+1)
- stage = s
REQ-022 The descriptor SHALL advance only on a cycle where bf_valid and bf_ready are both 1; otherwise all descriptor outputs SHALL hold stable.
REQ-023 When j reaches N/2-1 with s<L-1 and the descriptor is accepted, the block SHALL wrap j to 0 and increment s, with no bubble cycle.
REQ-024 Acceptance of the final descriptor (s=L-1, j=N/2-1) SHALL deassert bf_valid and busy next cycle, enter DONE, and pulse done for exactly one cycle; DONE SHALL then return to IDLE.
REQ-025 Total accepted descriptors per transform SHALL equal L*N/2.
REQ-026 All arithmetic SHALL be shift/mask only, with no multipliers; addr_b SHALL never exceed N-1.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state IDLE and set bf_valid, busy, done and cfg_err to 0, and addr_a, addr_b, tw_k, stage and counters to 0, with tw_n=2.
REQ-028 Reset asserted mid-RUN SHALL abandon the transform with no done pulse; a start is accepted on the first cycle after rst_n returns to 1.

Configuration
REQ-029 When macro FFT_SEQ_ABORT_EN is defined, the block SHALL add input port abort (1 bit); abort=1 in RUN SHALL return the FSM to IDLE next cycle with bf_valid=0 and no done pulse; abort is ignored in IDLE and DONE; abort has priority over a simultaneous handshake.
REQ-030 When FFT_SEQ_ABORT_EN is undefined, the abort port and its logic SHALL be absent, and a transform SHALL end only on completion or reset.

Verification
REQ-031 log2n=1, start, bf_ready=1 -> one descriptor (a=0, b=1, k=0, n=2, stage 0), then done pulse 2 cycles after start.
REQ-032 log2n=3, bf_ready=1 -> 12 descriptors:
- stage0 (a,b) = (0,1),(2,3),(4,5),(6,7), n=2
- stage1 = (0,2),(1,3),(4,6),(5,7), k=0,1,0,1, n=4
- stage2 = (0,4)..(3,7), k=0..3, n=8
- then done.
REQ-033 log2n=10 with bf_ready toggling pseudo-randomly -> outputs hold while not ready; exactly 5120 accepted; last descriptor a=511, b=1023, k=511, n=1024.
REQ-034 start with log2n=0, then log2n=11 -> cfg_err pulse each time, busy stays 0, no bf_valid.
REQ-035 rst_n=0 during stage 1 of log2n=4 -> all outputs at reset values next cycle; a following start runs a full 32-descriptor transform correctly.
REQ-036 FFT_SEQ_ABORT_EN defined, abort at descriptor 5 of log2n=3 -> bf_valid=0 and busy=0 next cycle, no done pulse; a new start is accepted afterwards.
